// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DefAddrW-1:0] reg_addr_t;
  typedef logic [DefDataW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: reservations set them, writes clear them,
// and a same-cycle reservation beats a clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned N_RD   = 2,
  parameter int unsigned N_WR   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [N_RD-1:0]          rd_ready_o,
  input  logic [N_WR-1:0]          wr_en_i,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i
);

  localparam int unsigned Depth = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [Depth-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int unsigned j = 0; j < N_WR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] != ZeroAddr)) begin
        pending_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    // Applied after the clears so a same-cycle reservation wins.
    if (rsv_en_i && (rsv_addr_i != ZeroAddr)) begin
      pending_d[rsv_addr_i] = 1'b1;
    end
    pending_d[ZeroAddr] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rd_ready_o = '0;
    for (int unsigned k = 0; k < N_RD; k++) begin
      rd_ready_o[k] = ~pending_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hardwired to zero and RAW scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned N_RD   = 2,
  parameter int unsigned N_WR   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_ready,
  input  logic [N_WR-1:0]          wr_en,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr,
  input  logic [N_WR*DATA_W-1:0]   wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int unsigned Depth = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [Depth-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [N_RD-1:0]              sb_ready;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD),
    .N_WR   (N_WR)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rst),
    .rd_addr_i  (rd_addr),
    .rd_ready_o (sb_ready),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr)
  );

  // Ascending port order lets the highest-index port win a collision.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned j = 0; j < N_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ZeroAddr)) begin
        mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
    end
    mem_d[ZeroAddr] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = sb_ready;
    for (int unsigned k = 0; k < N_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned j = 0; j < N_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W]) &&
            (rd_addr[k*ADDR_W +: ADDR_W] != ZeroAddr)) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
          rd_ready[k]                 = 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with hazard scoreboard, the next-generation architectural register file for the pipelined core. Provides N_RD combinational read ports and N_WR write ports. Register 0 is hardwired to zero. A per-register pending bit lets the decode/issue stage stall on RAW hazards without external tracking logic. Sits between decode (reads, reservations) and writeback (writes, pending clears).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- N_WR, 1, number of write ports (1..2)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- rd_addr  in  N_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data, packed the same way
- rd_ready  out  N_RD  1 = addressed register has no pending write
- wr_en  in  N_WR  per-port write enable
- wr_addr  in  N_WR*ADDR_W  write addresses
- wr_data  in  N_WR*DATA_W  write data
- rsv_en  in  1  reserve a destination register (marks it pending)
- rsv_addr  in  ADDR_W  register to reserve

## Operation
- Storage: 2**ADDR_W × DATA_W flops. Entry 0 always reads 0. Writes and reservations to address 0 are ignored, so rd_ready for address 0 is always 1.
- Reads are combinational: rd_data[k] = reg[rd_addr[k]]. Bypass behaviour is covered under Configuration.
- Write: on a rising edge with wr_en[j]=1 and wr_addr[j]≠0, reg[wr_addr[j]] ← wr_data[j]. The write also clears pending[wr_addr[j]].
- Write-write conflict: if two ports target the same address in one cycle, the higher port index wins for data.
- Reserve: on a rising edge with rsv_en=1 and rsv_addr≠0, pending[rsv_addr] ← 1.
- Reserve vs write on the same address in the same cycle: the reservation wins and pending ends at 1. Data is still written.
- rd_ready[k] = ~pending[rd_addr[k]], evaluated combinationally from registered pending bits.
- Reset (rst=0 at a rising edge): all registers ← 0 and all pending ← 0.
  - Reset overrides any write or reservation in the same cycle.
  - Reset applied mid-operation discards in-flight state.
- Output values after reset: every rd_data = 0 and every rd_ready = 1.

## Timing
- Read latency is 0 cycles (combinational from rd_addr). A written value becomes visible in storage 1 cycle after the write edge.
- A reservation raises pending, so rd_ready drops 1 cycle after the rsv_en edge.
- A write clears pending, so rd_ready rises 1 cycle after the write edge. With bypass compiled in, it rises in the same cycle as the write (see Configuration).
- No handshake on writes: every asserted wr_en is accepted in that cycle.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd_data[k] returns wr_data of the highest-index port j with wr_en[j]=1 and wr_addr[j]=rd_addr[k]≠0 in that same cycle.
  - rd_ready[k] is forced to 1 under the same match condition.
  - This gives write-then-read in one cycle.
- Undefined:
  - Reads return stored contents only; a same-cycle write is visible the following cycle.
  - rd_ready follows the registered pending bits only.

## Structure
- Package regfile_pkg:
  - default DATA_W and ADDR_W constants
  - ZERO_REG = 0
  - typedef for reg address and reg data
- Sub-module regfile_scoreboard:
  - holds the pending vector, reserve/clear logic and priority rules
  - produces per-port ready bits
  - instantiated once
- Top module holds storage, the write-priority mux, and the optional bypass mux.

## Test plan
- Reset: hold rst=0 for 2 cycles with wr_en=1 (addr 5, data 0xDEADBEEF) → all rd_data=0, all rd_ready=1 after release.
- Basic write/read: write 0x12345678 to r3 → next cycle, rd_addr0=3 reads 0x12345678; writing r0 with 0xFFFFFFFF → r0 still reads 0.
- Dual-write conflict (N_WR=2): port0 writes r7=0x1, port1 writes r7=0x2 in the same cycle → r7 reads 0x2.
- Scoreboard: reserve r9 → rd_ready=0 next cycle. Write r9=0xA → rd_ready=1 (same cycle with REGFILE_BYPASS_EN, next cycle without).
- Reserve and write r9 in the same cycle → pending stays 1 and r9 holds the written data.
- Bypass: with REGFILE_BYPASS_EN, write r4=0xCAFE while rd_addr1=4 → rd_data1=0xCAFE in the same cycle. Without the macro → old value that cycle, 0xCAFE the next.
